// File: rtl/vram_arbiter_pkg.sv
// Shared encodings for the video SRAM arbiter: bus owner and arbiter state,
// visible to the memory controller and debug logic.
package vram_arbiter_pkg;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int N_REQ  = 4;

    typedef enum logic [2:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_PAL, OWN_DMA} owner_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_TURN} arb_state_t;

    // Strobe vector ordered {dma, pal, cpu, vid}.
    function automatic logic [N_REQ-1:0] owner_onehot(input owner_t own);
        logic [N_REQ-1:0] v;
        v = '0;
        case (own)
            OWN_VID: v[0] = 1'b1;
            OWN_CPU: v[1] = 1'b1;
            OWN_PAL: v[2] = 1'b1;
            OWN_DMA: v[3] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/vram_arb_prio.sv
// Combinational grant picker: video > CPU > palette/DMA, with DMA forced
// ahead of palette once it has been skipped DMA_MAX_SKIP times.
module vram_arb_prio
    import vram_arbiter_pkg::*;
#(
    parameter int DMA_MAX_SKIP = 3,
    parameter int SKIP_W       = 2
) (
    input  logic              vid_req,
    input  logic              cpu_req,
    input  logic              pal_req,
    input  logic              dma_req,
    input  logic [SKIP_W-1:0] skip_cnt,
    output owner_t            grant
);
    logic dma_forced;

    assign dma_forced = dma_req && (skip_cnt == SKIP_W'(DMA_MAX_SKIP));

    always_comb begin
        grant = OWN_NONE;
        if (vid_req)
            grant = OWN_VID;
        else if (cpu_req)
            grant = OWN_CPU;
        else if (pal_req && !dma_forced)
            grant = OWN_PAL;
        else if (dma_req)
            grant = OWN_DMA;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Shared video SRAM bus sequencer: fixed-length slots, four requesters,
// write-to-read turnaround and CPU wait generation.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int          ACC_CYCLES   = 2,
    parameter logic [12:0] PAL_BASE     = 13'h1FFF,
    parameter int          DMA_MAX_SKIP = 3
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_valid,
    output logic              cpu_wait,
    input  logic              pal_req,
    input  logic              pal_wr,
    input  logic [5:0]        pal_idx,
    input  logic [DATA_W-1:0] pal_wdata,
    output logic              pal_ack,
    output logic              pal_valid,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic              dma_valid,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] vd_in,
    output logic [ADDR_W-1:0] va,
    output logic [DATA_W-1:0] vd_out,
    output logic              vd_oe,
    output logic              n_vrd,
    output logic              n_vwr
);
    localparam int         SKIP_W   = (DMA_MAX_SKIP < 1) ? 1 : $clog2(DMA_MAX_SKIP + 1);
    localparam logic [1:0] LAST_CNT = 2'(ACC_CYCLES - 1);

    arb_state_t        state_reg;
    owner_t            owner_reg;
    owner_t            grant;
    logic              wr_reg;
    logic [1:0]        cnt_reg;
    logic [SKIP_W-1:0] skip_reg;
    logic [ADDR_W-1:0] va_reg;
    logic [DATA_W-1:0] vd_out_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              vd_oe_reg;
    logic              n_vrd_reg;
    logic              n_vwr_reg;
    logic [N_REQ-1:0]  ack_reg;
    logic [N_REQ-1:0]  valid_reg;

    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              slot_last;
    logic              arb_now;
    logic              need_turn;
    logic              take;

    vram_arb_prio #(
        .DMA_MAX_SKIP (DMA_MAX_SKIP),
        .SKIP_W       (SKIP_W)
    ) u_prio (
        .vid_req  (vid_req),
        .cpu_req  (cpu_req),
        .pal_req  (pal_req),
        .dma_req  (dma_req),
        .skip_cnt (skip_reg),
        .grant    (grant)
    );

    always_comb begin
        grant_wr    = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        case (grant)
            OWN_VID: grant_addr = vid_addr;
            OWN_CPU: begin
                grant_wr    = cpu_wr;
                grant_addr  = cpu_addr;
                grant_wdata = cpu_wdata;
            end
            OWN_PAL: begin
                grant_wr    = pal_wr;
                grant_addr  = {PAL_BASE, pal_idx};
                grant_wdata = pal_wdata;
            end
            OWN_DMA: begin
                grant_wr    = dma_wr;
                grant_addr  = dma_addr;
                grant_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    // A read following a write must first spend one TURN cycle with vd released.
    assign slot_last = (state_reg == ARB_ACCESS) && (cnt_reg == LAST_CNT);
    assign arb_now   = (state_reg != ARB_ACCESS) || slot_last;
    assign need_turn = slot_last && wr_reg && (grant != OWN_NONE) && !grant_wr;
    assign take      = arb_now && (grant != OWN_NONE) && !need_turn;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ARB_IDLE;
            owner_reg  <= OWN_NONE;
            wr_reg     <= 1'b0;
            cnt_reg    <= '0;
            skip_reg   <= '0;
            va_reg     <= '0;
            vd_out_reg <= '0;
            rdata_reg  <= '0;
            vd_oe_reg  <= 1'b0;
            n_vrd_reg  <= 1'b1;
            n_vwr_reg  <= 1'b1;
            ack_reg    <= '0;
            valid_reg  <= '0;
        end else begin
            ack_reg   <= '0;
            valid_reg <= '0;
            if (slot_last) begin
                valid_reg <= owner_onehot(owner_reg);
                if (!wr_reg)
                    rdata_reg <= vd_in;
            end
            if (take) begin
                state_reg <= ARB_ACCESS;
                cnt_reg   <= '0;
                owner_reg <= grant;
                wr_reg    <= grant_wr;
                va_reg    <= grant_addr;
                if (grant_wr)
                    vd_out_reg <= grant_wdata;
                vd_oe_reg <= grant_wr;
                n_vrd_reg <= grant_wr;
                n_vwr_reg <= 1'b1;
                ack_reg   <= owner_onehot(grant);
                if (grant == OWN_DMA)
                    skip_reg <= '0;
                else if (grant == OWN_PAL && dma_req && skip_reg != SKIP_W'(DMA_MAX_SKIP))
                    skip_reg <= skip_reg + 1'b1;
            end else if (arb_now) begin
                state_reg <= need_turn ? ARB_TURN : ARB_IDLE;
                owner_reg <= OWN_NONE;
                wr_reg    <= 1'b0;
                vd_oe_reg <= 1'b0;
                n_vrd_reg <= 1'b1;
                n_vwr_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
                // Write strobe falls one cycle after address/data settle.
                if (wr_reg)
                    n_vwr_reg <= 1'b0;
            end
        end
    end

    assign cpu_wait  = cpu_req & ~((state_reg == ARB_ACCESS) && (owner_reg == OWN_CPU));
    assign vid_ack   = ack_reg[0];
    assign cpu_ack   = ack_reg[1];
    assign pal_ack   = ack_reg[2];
    assign dma_ack   = ack_reg[3];
    assign vid_valid = valid_reg[0];
    assign cpu_valid = valid_reg[1];
    assign pal_valid = valid_reg[2];
    assign dma_valid = valid_reg[3];
    assign rdata     = rdata_reg;
    assign va        = va_reg;
    assign vd_out    = vd_out_reg;
    assign vd_oe     = vd_oe_reg;
    assign n_vrd     = n_vrd_reg;
    assign n_vwr     = n_vwr_reg;
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed slots on an ACC_CYCLES=2 instance
// with an SRAM model, plus an ACC_CYCLES=4 instance for slot-length timing.
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    typedef struct {
        owner_t      own;
        logic [18:0] addr;
    } ack_exp_t;

    typedef struct {
        owner_t      own;
        logic [18:0] addr;
        logic        rd;
        logic [7:0]  data;
    } val_exp_t;

    logic clk28 = 1'b0;
    always #5 clk28 = ~clk28;

    logic        rst_n;
    logic        vid_req, cpu_req, cpu_wr, pal_req, pal_wr, dma_req, dma_wr;
    logic [18:0] vid_addr, cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, pal_wdata, dma_wdata;
    logic [5:0]  pal_idx;
    logic        vid_ack, vid_valid, cpu_ack, cpu_valid, cpu_wait;
    logic        pal_ack, pal_valid, dma_ack, dma_valid;
    logic [7:0]  rdata, vd_in, vd_out;
    logic [18:0] va;
    logic        vd_oe, n_vrd, n_vwr;

    // ACC_CYCLES=4 instance signals
    logic        v4_req;
    logic [18:0] v4_addr, v4_va;
    logic        v4_ack, v4_valid, v4_n_vrd, v4_n_vwr, v4_vd_oe;
    logic        v4_cpu_ack, v4_cpu_valid, v4_cpu_wait;
    logic        v4_pal_ack, v4_pal_valid, v4_dma_ack, v4_dma_valid;
    logic [7:0]  v4_rdata, v4_vd_out, v4_vd_in, v4_vd_val;

    logic [7:0]  mem [0:(1<<19)-1];
    logic        pre_we;
    logic [18:0] pre_addr;
    logic [7:0]  pre_data;

    ack_exp_t ack_q[$];
    val_exp_t val_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.ACC_CYCLES(2), .PAL_BASE(13'h1FFF), .DMA_MAX_SKIP(3)) dut (
        .clk28(clk28), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_wait(cpu_wait),
        .pal_req(pal_req), .pal_wr(pal_wr), .pal_idx(pal_idx), .pal_wdata(pal_wdata),
        .pal_ack(pal_ack), .pal_valid(pal_valid),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_valid(dma_valid),
        .rdata(rdata), .vd_in(vd_in), .va(va), .vd_out(vd_out), .vd_oe(vd_oe),
        .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    vram_arbiter #(.ACC_CYCLES(4), .PAL_BASE(13'h1FFF), .DMA_MAX_SKIP(3)) dut4 (
        .clk28(clk28), .rst_n(rst_n),
        .vid_req(v4_req), .vid_addr(v4_addr), .vid_ack(v4_ack), .vid_valid(v4_valid),
        .cpu_req(1'b0), .cpu_wr(1'b0), .cpu_addr(19'h0), .cpu_wdata(8'h00),
        .cpu_ack(v4_cpu_ack), .cpu_valid(v4_cpu_valid), .cpu_wait(v4_cpu_wait),
        .pal_req(1'b0), .pal_wr(1'b0), .pal_idx(6'h00), .pal_wdata(8'h00),
        .pal_ack(v4_pal_ack), .pal_valid(v4_pal_valid),
        .dma_req(1'b0), .dma_wr(1'b0), .dma_addr(19'h0), .dma_wdata(8'h00),
        .dma_ack(v4_dma_ack), .dma_valid(v4_dma_valid),
        .rdata(v4_rdata), .vd_in(v4_vd_in), .va(v4_va), .vd_out(v4_vd_out), .vd_oe(v4_vd_oe),
        .n_vrd(v4_n_vrd), .n_vwr(v4_n_vwr)
    );

    // SRAM model: asynchronous read while n_vrd is low, write on clock while n_vwr is low.
    always @(posedge clk28) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (!n_vwr && vd_oe)
            mem[va] <= vd_out;
    end
    assign vd_in    = n_vrd ? 8'h00 : mem[va];
    assign v4_vd_in = v4_n_vrd ? 8'h00 : v4_vd_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] own_bits(input owner_t o);
        case (o)
            OWN_VID: return 4'b0001;
            OWN_CPU: return 4'b0010;
            OWN_PAL: return 4'b0100;
            OWN_DMA: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic nxt();
        @(negedge clk28);
    endtask

    task automatic poke(input logic [18:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        nxt();
        pre_we   = 1'b0;
    endtask

    task automatic expect_txn(input owner_t o, input logic [18:0] a, input logic rd,
                              input logic [7:0] d, input logic completes);
        ack_exp_t ea;
        val_exp_t ev;
        ea.own = o; ea.addr = a;
        ack_q.push_back(ea);
        if (completes) begin
            ev.own = o; ev.addr = a; ev.rd = rd; ev.data = d;
            val_q.push_back(ev);
        end
    endtask

    always @(negedge clk28) begin : monitor
        ack_exp_t   ea;
        val_exp_t   ev;
        logic [3:0] a_bits;
        logic [3:0] v_bits;
        a_bits = {dma_ack, pal_ack, cpu_ack, vid_ack};
        v_bits = {dma_valid, pal_valid, cpu_valid, vid_valid};
        if (a_bits != 4'b0000) begin
            if (ack_q.size() == 0) begin
                chk("sb_ack_unexpected", {28'h0, a_bits}, 32'h0);
            end else begin
                ea = ack_q.pop_front();
                chk("sb_ack_owner", {28'h0, a_bits}, {28'h0, own_bits(ea.own)});
                chk("sb_ack_va", {13'h0, va}, {13'h0, ea.addr});
            end
        end
        if (v_bits != 4'b0000) begin
            if (val_q.size() == 0) begin
                chk("sb_valid_unexpected", {28'h0, v_bits}, 32'h0);
            end else begin
                ev = val_q.pop_front();
                chk("sb_valid_owner", {28'h0, v_bits}, {28'h0, own_bits(ev.own)});
                if (ev.rd)
                    chk("sb_rdata", {24'h0, rdata}, {24'h0, ev.data});
                $display("txn %s %s addr=0x%05h rdata=0x%02h", ev.own.name(),
                         ev.rd ? "rd" : "wr", ev.addr, rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        owner_t pd_seq [8];
        int     seen;
        int     guard;
        pd_seq = '{OWN_PAL, OWN_PAL, OWN_PAL, OWN_DMA, OWN_PAL, OWN_PAL, OWN_PAL, OWN_DMA};
        rst_n = 1'b0;
        vid_req = 0; cpu_req = 0; cpu_wr = 0; pal_req = 0; pal_wr = 0; dma_req = 0; dma_wr = 0;
        vid_addr = '0; cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; pal_wdata = '0;
        dma_wdata = '0; pal_idx = '0;
        v4_req = 0; v4_addr = '0; v4_vd_val = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        repeat (3) nxt();

        // Reset values
        chk("rst_va", {13'h0, va}, 32'h0);
        chk("rst_vd_out", {24'h0, vd_out}, 32'h0);
        chk("rst_strobes", {29'h0, vd_oe, n_vrd, n_vwr}, 32'h3);
        chk("rst_rdata", {24'h0, rdata}, 32'h0);
        chk("rst_ack_valid", {24'h0, vid_ack, cpu_ack, pal_ack, dma_ack,
                              vid_valid, cpu_valid, pal_valid, dma_valid}, 32'h0);
        chk("rst_cpu_wait", {31'h0, cpu_wait}, 32'h0);
        rst_n = 1'b1;
        nxt();
        chk("rst_state", {30'h0, dut.state_reg}, {30'h0, ARB_IDLE});

        poke(19'h00100, 8'h11);
        poke(19'h00200, 8'h22);
        poke(19'h7FFD5, 8'hA5);
        poke(19'h12345, 8'h3C);
        poke(19'h00000, 8'h77);
        poke(19'h00001, 8'h88);
        poke(19'h00055, 8'h00);
        nxt();

        // Video and CPU requested together: video first, CPU waits
        vid_req = 1; vid_addr = 19'h00100;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h00200;
        expect_txn(OWN_VID, 19'h00100, 1'b1, 8'h11, 1'b1);
        expect_txn(OWN_CPU, 19'h00200, 1'b1, 8'h22, 1'b1);
        #1 chk("t1_wait_t0", {31'h0, cpu_wait}, 32'h1);
        nxt();
        chk("t1_vid_ack", {31'h0, vid_ack}, 32'h1);
        chk("t1_wait_t1", {31'h0, cpu_wait}, 32'h1);
        vid_req = 0;
        nxt();
        chk("t1_wait_t2", {31'h0, cpu_wait}, 32'h1);
        chk("t1_cpu_ack_t2", {31'h0, cpu_ack}, 32'h0);
        nxt();
        chk("t1_cpu_ack_t3", {31'h0, cpu_ack}, 32'h1);
        chk("t1_wait_t3", {31'h0, cpu_wait}, 32'h0);
        chk("t1_vid_valid_t3", {31'h0, vid_valid}, 32'h1);
        cpu_req = 0;
        nxt();
        chk("t1_cpu_valid_t4", {31'h0, cpu_valid}, 32'h0);
        nxt();
        chk("t1_cpu_valid_t5", {31'h0, cpu_valid}, 32'h1);
        nxt();

        // CPU write then video read of the same address, with one TURN cycle
        cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h04000; cpu_wdata = 8'h5A;
        expect_txn(OWN_CPU, 19'h04000, 1'b0, 8'h00, 1'b1);
        nxt();
        chk("t2_cpu_ack", {31'h0, cpu_ack}, 32'h1);
        chk("t2_c0_oe_wr", {30'h0, vd_oe, n_vwr}, 32'h3);
        chk("t2_vd_out", {24'h0, vd_out}, 32'h5A);
        cpu_req = 0; cpu_wr = 0;
        vid_req = 1; vid_addr = 19'h04000;
        expect_txn(OWN_VID, 19'h04000, 1'b1, 8'h5A, 1'b1);
        nxt();
        chk("t2_c1_oe_wr", {30'h0, vd_oe, n_vwr}, 32'h2);
        nxt();
        chk("t2_turn_bus", {29'h0, vd_oe, n_vrd, n_vwr}, 32'h3);
        chk("t2_turn_acks", {30'h0, vid_ack, cpu_valid}, 32'h1);
        chk("t2_rdata_hold", {24'h0, rdata}, 32'h22);
        nxt();
        chk("t2_vid_ack", {30'h0, vid_ack, n_vrd}, 32'h2);
        vid_req = 0;
        nxt();
        nxt();
        chk("t2_vid_valid", {31'h0, vid_valid}, 32'h1);
        chk("t2_rdata", {24'h0, rdata}, 32'h5A);
        nxt();

        // Palette and DMA held: PAL,PAL,PAL,DMA repeating
        pal_req = 1; pal_wr = 0; pal_idx = 6'h15;
        dma_req = 1; dma_wr = 0; dma_addr = 19'h12345;
        for (int i = 0; i < 8; i++)
            expect_txn(pd_seq[i], (pd_seq[i] == OWN_PAL) ? 19'h7FFD5 : 19'h12345, 1'b1,
                       (pd_seq[i] == OWN_PAL) ? 8'hA5 : 8'h3C, 1'b1);
        seen = 0;
        guard = 0;
        while (seen < 8 && guard < 40) begin
            nxt();
            if (pal_ack || dma_ack)
                seen++;
            guard++;
        end
        chk("t3_grant_count", seen, 8);
        pal_req = 0; dma_req = 0;
        repeat (3) nxt();

        // Back-to-back CPU reads with no idle gap
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h00000;
        expect_txn(OWN_CPU, 19'h00000, 1'b1, 8'h77, 1'b1);
        nxt();
        chk("t4_s0", {30'h0, cpu_ack, n_vrd}, 32'h2);
        cpu_addr = 19'h00001;
        expect_txn(OWN_CPU, 19'h00001, 1'b1, 8'h88, 1'b1);
        nxt();
        chk("t4_s1_nvrd", {31'h0, n_vrd}, 32'h0);
        nxt();
        chk("t4_s2", {29'h0, cpu_ack, cpu_valid, n_vrd}, 32'h6);
        cpu_req = 0;
        nxt();
        chk("t4_s3", {30'h0, cpu_valid, n_vrd}, 32'h0);
        nxt();
        chk("t4_s4", {30'h0, cpu_valid, n_vrd}, 32'h3);
        nxt();

        // Reset during cycle 1 of a DMA write
        dma_req = 1; dma_wr = 1; dma_addr = 19'h00055; dma_wdata = 8'hEE;
        expect_txn(OWN_DMA, 19'h00055, 1'b0, 8'h00, 1'b0);
        nxt();
        chk("t5_dma_ack", {30'h0, dma_ack, vd_oe}, 32'h3);
        dma_req = 0; dma_wr = 0;
        nxt();
        chk("t5_c1_nvwr", {31'h0, n_vwr}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bus", {29'h0, vd_oe, n_vrd, n_vwr}, 32'h3);
        chk("t5_rst_va", {13'h0, va}, 32'h0);
        nxt();
        chk("t5_rst_dma_valid", {31'h0, dma_valid}, 32'h0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("t5_state", {30'h0, dut.state_reg}, {30'h0, ARB_IDLE});
        chk("t5_skip", {30'h0, dut.skip_reg}, 32'h0);
        chk("t5_outs", {13'h0, va}, 32'h0);
        chk("t5_bus", {16'h0, rdata, vd_out}, 32'h0);
        chk("t5_strobes", {29'h0, vd_oe, n_vrd, n_vwr}, 32'h3);
        chk("t5_dma_valid", {31'h0, dma_valid}, 32'h0);
        chk("t5_mem", {24'h0, mem[19'h00055]}, 32'h0);
        nxt();

        // ACC_CYCLES=4 video read
        v4_req = 1; v4_addr = 19'h3ABCD; v4_vd_val = 8'hC3;
        nxt();
        chk("t6_ack", {30'h0, v4_ack, v4_n_vrd}, 32'h2);
        chk("t6_va", {13'h0, v4_va}, 32'h3ABCD);
        v4_req = 0;
        for (int k = 1; k < 4; k++) begin
            nxt();
            chk("t6_slot", {30'h0, v4_valid, v4_n_vrd}, 32'h0);
            if (k == 3)
                v4_vd_val = 8'h3C;
        end
        nxt();
        chk("t6_valid", {30'h0, v4_valid, v4_n_vrd}, 32'h3);
        chk("t6_rdata", {24'h0, v4_rdata}, 32'h3C);
        $display("txn VID4 rd addr=0x%05h rdata=0x%02h", v4_addr, v4_rdata);
        repeat (3) nxt();

        chk("sb_ack_drained", ack_q.size(), 0);
        chk("sb_valid_drained", val_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
